// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and address-counter stepping for the HD44780 responder.
package lcd_pkg;

    localparam logic [7:0] MASK_DDRAM = 8'h80;
    localparam logic [7:0] PFX_DDRAM  = 8'h80;
    localparam logic [7:0] MASK_CGRAM = 8'hC0;
    localparam logic [7:0] PFX_CGRAM  = 8'h40;
    localparam logic [7:0] MASK_FUNC  = 8'hE0;
    localparam logic [7:0] PFX_FUNC   = 8'h20;
    localparam logic [7:0] MASK_SHIFT = 8'hF0;
    localparam logic [7:0] PFX_SHIFT  = 8'h10;
    localparam logic [7:0] MASK_DISP  = 8'hF8;
    localparam logic [7:0] PFX_DISP   = 8'h08;
    localparam logic [7:0] MASK_ENTRY = 8'hFC;
    localparam logic [7:0] PFX_ENTRY  = 8'h04;
    localparam logic [7:0] MASK_HOME  = 8'hFE;
    localparam logic [7:0] PFX_HOME   = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h01;

    localparam logic [6:0] LINE0_BASE = 7'h00;
    localparam logic [6:0] LINE1_BASE = 7'h40;
    localparam int unsigned LINE_LEN  = 16;
    localparam logic [6:0] LINE0_LAST = 7'h27;
    localparam logic [6:0] LINE1_LAST = 7'h67;

    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_HOME,
        ST_CLEAR
    } lcd_state_e;

    // AC wraps between the two 40-character line windows rather than across the gaps.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (ac == LINE0_LAST)      r = LINE1_BASE;
            else if (ac == LINE1_LAST) r = LINE0_BASE;
            else                       r = ac + 7'd1;
        end else begin
            if (ac == LINE0_BASE)      r = LINE1_LAST;
            else if (ac == LINE1_BASE) r = LINE0_LAST;
            else                       r = ac - 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_e_sync.sv
// Two-flop synchroniser for the bus enable strobe with rise/fall pulses.
module lcd_e_sync (
    input  logic clk,
    input  logic reset,
    input  logic e_i,
    output logic e_sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= e_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign e_sync_o = sync_q;
    assign rise_o   = sync_q & ~prev_q;
    assign fall_o   = ~sync_q & prev_q;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible bus responder: instruction decode, DDRAM, busy timing and a scan read port.
module lcd_hd44780_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES = 2000,
    parameter int unsigned HOME_CYCLES = 76000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RS,
    input  logic       RW,
    input  logic       E,
    input  logic [7:0] DATA_in,
    output logic [7:0] DATA_out,
    output logic       DATA_oe,
    input  logic [6:0] disp_addr,
    output logic [7:0] disp_char,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       entry_shift,
    output logic       busy,
    output logic       cmd_dropped
);

    localparam int unsigned MAXC = (HOME_CYCLES > BUSY_CYCLES) ? HOME_CYCLES : BUSY_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    logic e_sync, e_rise, e_fall;

    lcd_e_sync u_e_sync (
        .clk     (clk),
        .reset   (reset),
        .e_i     (E),
        .e_sync_o(e_sync),
        .rise_o  (e_rise),
        .fall_o  (e_fall)
    );

    logic       cap_rs_q, cap_rw_q, cap_valid_q;
    logic [7:0] cap_data_q;

    // cap_valid_q keeps DATA_oe from acting on a stale RW during the first synced-E cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_rs_q    <= 1'b0;
            cap_rw_q    <= 1'b0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            if (e_sync) begin
                cap_rs_q   <= RS;
                cap_rw_q   <= RW;
                cap_data_q <= DATA_in;
            end
            if (e_rise)      cap_valid_q <= 1'b1;
            else if (e_fall) cap_valid_q <= 1'b0;
        end
    end

    lcd_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0] fill_q, fill_d;
    logic [6:0] ac_q, ac_d;
    logic disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
    logic inc_q, inc_d, shift_q, shift_d;
    logic dropped_q, dropped_d;
    logic [7:0] disp_char_q;

    logic [7:0] ddram_q [128];
    logic       ddram_we;
    logic [6:0] ddram_waddr;
    logic [7:0] ddram_wdata;

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        ac_d        = ac_q;
        disp_d      = disp_q;
        cur_d       = cur_q;
        blink_d     = blink_q;
        inc_d       = inc_q;
        shift_d     = shift_q;
        dropped_d   = dropped_q;
        ddram_we    = 1'b0;
        ddram_waddr = ac_q;
        ddram_wdata = cap_data_q;

        case (state_q)
            ST_EXEC, ST_HOME: begin
                if (cnt_q == '0) state_d = ST_IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            ST_CLEAR: begin
                ddram_we    = 1'b1;
                ddram_waddr = fill_q;
                ddram_wdata = CHAR_SPACE;
                fill_d      = fill_q + 7'd1;
                if (fill_q == 7'h7F) begin
                    if (HOME_CYCLES > 128) begin
                        state_d = ST_HOME;
                        cnt_d   = CW'(HOME_CYCLES - 129);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: ;
        endcase

        // Commits are only honoured in IDLE, so they never collide with the counters above.
        if (e_fall) begin
            if (cap_rw_q) begin
                if (cap_rs_q && !busy) begin
                    ac_d    = ac_step(ac_q, inc_q);
                    state_d = ST_EXEC;
                    cnt_d   = CW'(BUSY_CYCLES - 1);
                end
            end else if (busy) begin
                dropped_d = 1'b1;
            end else if (cap_rs_q) begin
                ddram_we    = 1'b1;
                ddram_waddr = ac_q;
                ddram_wdata = cap_data_q;
                ac_d        = ac_step(ac_q, inc_q);
                state_d     = ST_EXEC;
                cnt_d       = CW'(BUSY_CYCLES - 1);
            end else if (cap_data_q != 8'h00) begin
                state_d = ST_EXEC;
                cnt_d   = CW'(BUSY_CYCLES - 1);
                if ((cap_data_q & MASK_DDRAM) == PFX_DDRAM) begin
                    ac_d = cap_data_q[6:0];
                end else if ((cap_data_q & MASK_CGRAM) == PFX_CGRAM) begin
                    ac_d = ac_q;
                end else if ((cap_data_q & MASK_FUNC) == PFX_FUNC) begin
                    ac_d = ac_q;
                end else if ((cap_data_q & MASK_SHIFT) == PFX_SHIFT) begin
                    if (!cap_data_q[3]) ac_d = ac_step(ac_q, cap_data_q[2]);
                end else if ((cap_data_q & MASK_DISP) == PFX_DISP) begin
                    disp_d  = cap_data_q[2];
                    cur_d   = cap_data_q[1];
                    blink_d = cap_data_q[0];
                end else if ((cap_data_q & MASK_ENTRY) == PFX_ENTRY) begin
                    inc_d   = cap_data_q[1];
                    shift_d = cap_data_q[0];
                end else if ((cap_data_q & MASK_HOME) == PFX_HOME) begin
                    ac_d    = '0;
                    state_d = ST_HOME;
                    cnt_d   = CW'(HOME_CYCLES - 1);
                end else if (cap_data_q == CMD_CLEAR) begin
                    ac_d    = '0;
                    inc_d   = 1'b1;
                    fill_d  = '0;
                    state_d = ST_CLEAR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fill_q      <= '0;
            ac_q        <= '0;
            disp_q      <= 1'b0;
            cur_q       <= 1'b0;
            blink_q     <= 1'b0;
            inc_q       <= 1'b1;
            shift_q     <= 1'b0;
            dropped_q   <= 1'b0;
            disp_char_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            ac_q        <= ac_d;
            disp_q      <= disp_d;
            cur_q       <= cur_d;
            blink_q     <= blink_d;
            inc_q       <= inc_d;
            shift_q     <= shift_d;
            dropped_q   <= dropped_d;
            disp_char_q <= ddram_q[disp_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (ddram_we) ddram_q[ddram_waddr] <= ddram_wdata;
    end

    assign DATA_oe     = e_sync & cap_valid_q & cap_rw_q;
    assign DATA_out    = !DATA_oe ? '0 : (cap_rs_q ? ddram_q[ac_q] : {busy, ac_q});
    assign disp_char   = disp_char_q;
    assign display_on  = disp_q;
    assign cursor_on   = cur_q;
    assign blink_on    = blink_q;
    assign entry_inc   = inc_q;
    assign entry_shift = shift_q;
    assign cmd_dropped = dropped_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for the HD44780 responder using short busy/home timings.
module tb_lcd_hd44780_responder;

    localparam int unsigned BUSY = 20;
    localparam int unsigned HOME = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       RS = 1'b0, RW = 1'b0, E = 1'b0;
    logic [7:0] DATA_in = '0;
    logic [7:0] DATA_out;
    logic       DATA_oe;
    logic [6:0] disp_addr = '0;
    logic [7:0] disp_char;
    logic       display_on, cursor_on, blink_on, entry_inc, entry_shift, busy, cmd_dropped;

    int tests = 0;
    int fails = 0;

    lcd_hd44780_responder #(.BUSY_CYCLES(BUSY), .HOME_CYCLES(HOME)) dut (
        .clk        (clk),
        .reset      (reset),
        .RS         (RS),
        .RW         (RW),
        .E          (E),
        .DATA_in    (DATA_in),
        .DATA_out   (DATA_out),
        .DATA_oe    (DATA_oe),
        .disp_addr  (disp_addr),
        .disp_char  (disp_char),
        .display_on (display_on),
        .cursor_on  (cursor_on),
        .blink_on   (blink_on),
        .entry_inc  (entry_inc),
        .entry_shift(entry_shift),
        .busy       (busy),
        .cmd_dropped(cmd_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns three clocks after E falls: the commit has happened and busy is visible.
    task automatic access(input logic rs, input logic rw, input logic [7:0] d,
                          output logic [7:0] rd, output logic oe);
        @(negedge clk);
        RS = rs; RW = rw; DATA_in = d; E = 1'b1;
        repeat (6) @(negedge clk);
        rd = DATA_out;
        oe = DATA_oe;
        E = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic cmd(input logic rs, input logic [7:0] d);
        logic [7:0] rd;
        logic oe;
        int n;
        access(rs, 1'b0, d, rd, oe);
        wait_idle(n);
    endtask

    task automatic check_status(input string tag, input logic [7:0] exp);
        logic [7:0] rd;
        logic oe;
        access(1'b0, 1'b1, 8'h00, rd, oe);
        check({tag, "_oe"}, {31'd0, oe}, 32'd1);
        check(tag, {24'd0, rd}, {24'd0, exp});
    endtask

    task automatic check_disp(input string tag, input logic [6:0] a, input logic [7:0] exp);
        @(negedge clk);
        disp_addr = a;
        @(negedge clk);
        check(tag, {24'd0, disp_char}, {24'd0, exp});
    endtask

    task automatic check_all_spaces(input string tag);
        int bad;
        bad = 0;
        for (int unsigned i = 0; i < 128; i++) begin
            @(negedge clk);
            disp_addr = 7'(i);
            @(negedge clk);
            if (disp_char !== 8'h20) bad++;
        end
        check(tag, bad, 32'd0);
    endtask

    initial begin
        logic [7:0] rd;
        logic oe;
        int n;

        #1;
        check("rst_disp_char", {24'd0, disp_char}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_oe", {31'd0, DATA_oe}, 32'd0);
        check("rst_data_out", {24'd0, DATA_out}, 32'h00);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check_status("rst_status", 8'h00);
        check("rst_display_on", {31'd0, display_on}, 32'd0);
        check("rst_entry_inc", {31'd0, entry_inc}, 32'd1);
        check("rst_entry_shift", {31'd0, entry_shift}, 32'd0);
        check("rst_dropped", {31'd0, cmd_dropped}, 32'd0);

        cmd(1'b0, 8'h80);
        cmd(1'b1, 8'h41);
        cmd(1'b1, 8'h42);
        check_status("ac_after_two", 8'h02);
        check_disp("ddram0", 7'h00, 8'h41);
        check_disp("ddram1", 7'h01, 8'h42);

        access(1'b1, 1'b0, 8'h43, rd, oe);
        check("exec_busy_rise", {31'd0, busy}, 32'd1);
        wait_idle(n);
        check("exec_busy_len", n, BUSY);

        cmd(1'b0, 8'hA7);
        cmd(1'b1, 8'h55);
        check_disp("ddram27", 7'h27, 8'h55);
        check_status("wrap_27_to_40", 8'h40);
        cmd(1'b0, 8'h04);
        check("entry_dec", {31'd0, entry_inc}, 32'd0);
        cmd(1'b0, 8'h80);
        cmd(1'b1, 8'h66);
        check_disp("ddram0_dec", 7'h00, 8'h66);
        check_status("wrap_00_to_67", 8'h67);

        cmd(1'b0, 8'h07);
        check("entry_inc_set", {31'd0, entry_inc}, 32'd1);
        check("entry_shift_set", {31'd0, entry_shift}, 32'd1);
        cmd(1'b0, 8'h06);
        cmd(1'b0, 8'hA7);
        access(1'b1, 1'b1, 8'h00, rd, oe);
        check("data_read_oe", {31'd0, oe}, 32'd1);
        check("data_read_val", {24'd0, rd}, 32'h55);
        wait_idle(n);
        check_status("data_read_ac", 8'h40);

        cmd(1'b0, 8'h85);
        cmd(1'b0, 8'h14);
        check_status("shift_right", 8'h06);
        cmd(1'b0, 8'h10);
        check_status("shift_left", 8'h05);
        cmd(1'b0, 8'h18);
        check_status("display_shift_keeps_ac", 8'h05);

        access(1'b0, 1'b0, 8'h00, rd, oe);
        check("nop_no_busy", {31'd0, busy}, 32'd0);

        cmd(1'b0, 8'h0F);
        check("display_on", {31'd0, display_on}, 32'd1);
        check("cursor_on", {31'd0, cursor_on}, 32'd1);
        check("blink_on", {31'd0, blink_on}, 32'd1);
        access(1'b0, 1'b0, 8'h0F, rd, oe);
        check_status("status_busy", 8'h85);
        wait_idle(n);
        check_status("status_idle", 8'h05);

        access(1'b0, 1'b0, 8'h02, rd, oe);
        wait_idle(n);
        check("home_busy_len", n, HOME);
        check_status("home_ac", 8'h00);
        check("dropped_still_clear", {31'd0, cmd_dropped}, 32'd0);

        cmd(1'b0, 8'h04);
        access(1'b0, 1'b0, 8'h01, rd, oe);
        wait_idle(n);
        check("clear_busy_len", n, HOME);
        check("clear_entry_inc", {31'd0, entry_inc}, 32'd1);
        check_status("clear_ac", 8'h00);
        check_all_spaces("clear_fill");

        access(1'b0, 1'b0, 8'h01, rd, oe);
        check_status("status_during_clear", 8'h80);
        access(1'b1, 1'b0, 8'h33, rd, oe);
        check("dropped_set", {31'd0, cmd_dropped}, 32'd1);
        wait_idle(n);
        check_disp("dropped_write_ignored", 7'h00, 8'h20);
        check_status("dropped_ac", 8'h00);

        cmd(1'b0, 8'h80);
        cmd(1'b1, 8'h58);
        cmd(1'b0, 8'hC0);
        cmd(1'b1, 8'h59);
        access(1'b0, 1'b0, 8'h01, rd, oe);
        repeat (40) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midclear_busy", {31'd0, busy}, 32'd0);
        check("midclear_dropped", {31'd0, cmd_dropped}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        check_status("midclear_status", 8'h00);
        access(1'b0, 1'b0, 8'h01, rd, oe);
        wait_idle(n);
        check("reclear_busy_len", n, HOME);
        check_all_spaces("reclear_fill");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Synthesizable HD44780-compatible device model. It is the display end of the RS/RW/E/DATA bus that the team's 16x2 LCD Avalon controller drives.
- Decodes instructions and data writes, holds DDRAM and the display control flags, and answers busy-flag and DDRAM reads.
- Exposes a second read port so a video/scan block can render the 16x2 contents. It also serves as the bus responder in LCD controller benches.

Parameters:
- BUSY_CYCLES, 2000, clk cycles busy after a normal instruction or data access (40 us at 50 MHz)
- HOME_CYCLES, 76000, clk cycles busy after return home (1.52 ms at 50 MHz); must be >= 128

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- RS  in  1  register select: 0 = instruction/status, 1 = DDRAM data
- RW  in  1  1 = read, 0 = write
- E  in  1  enable strobe, asynchronous to clk
- DATA_in  in  8  bus data from the controller
- DATA_out  out  8  bus data returned on reads
- DATA_oe  out  1  drive enable for DATA_out
- disp_addr  in  7  scan-side DDRAM address
- disp_char  out  8  DDRAM[disp_addr], registered, 1-cycle latency
- display_on, cursor_on, blink_on  out  1 each  display control flags
- entry_inc, entry_shift  out  1 each  entry mode flags (I/D, S)
- busy  out  1  busy flag (BF)
- cmd_dropped  out  1  sticky; set when a write arrives while busy; cleared only by reset

Behaviour:
- Reset (async, reset=0):
  - Outputs: AC=0, busy=0, DATA_oe=0, DATA_out=0, display_on=0, cursor_on=0, blink_on=0, entry_inc=1, entry_shift=0, cmd_dropped=0, disp_char=0.
  - DDRAM contents are not reset.
  - State = IDLE.
  - Reset mid-clear aborts the fill. The remaining DDRAM contents are don't-care.
- E synchronisation:
  - 2-flop synchroniser on E. RS, RW and DATA_in are registered every cycle while sync-E=1.
  - A falling edge of sync-E commits the access using the last captured values.
  - Commit occurs 3 clk after the E pin falls.
- Reads (RW=1):
  - DATA_oe=1 while sync-E=1 and captured RW=1.
  - RS=0: DATA_out={busy, AC}. Status reads are legal while busy.
  - RS=1: DATA_out=DDRAM[AC]. On commit, AC advances per entry_inc.
  - A data read while busy returns DDRAM[AC], does not advance AC, and does not set cmd_dropped.
- Writes (RW=0):
  - A write committed while busy=1 is ignored and sets cmd_dropped.
  - RS=1: DDRAM[AC] <= data, AC advances, then EXEC.
  - RS=0: priority decode on the highest set bit:
    - 1xxxxxxx: AC <= data[6:0], EXEC
    - 01xxxxxx: CGRAM address set, accepted and ignored, EXEC
    - 001xxxxx: function set, accepted and ignored, EXEC
    - 0001xxxx: cursor/display shift; data[3]=0 moves AC by data[2] (1 = right/+1, 0 = left/-1), EXEC
    - 00001DCB: display_on=D, cursor_on=C, blink_on=B, EXEC
    - 000001IS: entry_inc=I, entry_shift=S, EXEC
    - 0000001x: AC <= 0, HOME
    - 00000001: AC <= 0, entry_inc <= 1, CLEAR
    - 00000000: no-op, no busy
- AC advance:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00, otherwise +1 mod 128.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27, otherwise -1 mod 128.
  - entry_shift is stored and output only; DDRAM contents are never shifted.
- FSM:
  - IDLE.
  - EXEC: busy=1, count BUSY_CYCLES, then IDLE.
  - HOME: busy=1, count HOME_CYCLES, then IDLE.
  - CLEAR: busy=1, write 0x20 to DDRAM index 0..127 one per cycle, then load count with HOME_CYCLES-128 and continue as HOME.
  - busy rises in the cycle after commit and is visible in the next status read.
- Memory: DDRAM is 128x8, dual-read. The bus port has priority for writes; the scan port is read-only.

Decomposition:
- Package lcd_pkg holds:
  - instruction opcode masks and prefixes
  - line base addresses 0x00 and 0x40, line length 16, line wrap limits 0x27 and 0x67
  - the space code 0x20
  - the responder state enum (IDLE, EXEC, HOME, CLEAR)
- Sub-module lcd_e_sync: 2-flop synchroniser plus rise/fall pulse generation.
- DDRAM is inferred inline.

Test Plan:
- Reset low then high. Status read returns 0x00; display_on=0; entry_inc=1.
- Write instruction 0x80 then data 0x41, 0x42, each after busy clears. DDRAM[0]=0x41, DDRAM[1]=0x42; status read returns 0x02.
- Write 0xA7 (AC=0x27), then data 0x55. DDRAM[0x27]=0x55; AC=0x40. Write 0x04 (decrement) and data 0x66 at AC=0x00: AC becomes 0x67.
- Write 0x01. busy=1 for HOME_CYCLES clk. All 128 entries read 0x20 via disp_addr; AC=0. A data write during clear is ignored and sets cmd_dropped=1.
- Write 0x0F. display_on=cursor_on=blink_on=1. Status read immediately after returns 0x80|AC. After BUSY_CYCLES it returns 0x00|AC.
- Assert reset mid-CLEAR at fill index 40. busy=0 and state IDLE immediately. A new write of 0x01 completes normally.
